mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single 32x32 unified memory port between the CPU datapath and the host loader.
//  The host loader writes instructions before a run and reads the result afterwards.
//  Uses a round-robin FSM with a burst limit and drives mem_addr/mem_wdata/mem_we to the memory.
//  The memory reads combinationally and writes on negedge clk.
//  Returns registered read data to whichever requester made the read.
// PARAMETERS
//  ADDR_W     5   memory address width (32 words)
//  DATA_W     32  memory data width
//  MAX_BURST  4   max consecutive accepted transactions per owner while the other requests (>=1)
// PORTS
//  clk          in   1       system clock; all state on posedge
//  rst_n        in   1       asynchronous, active-low reset
//  cpu_req      in   1       CPU command valid; cpu_we/addr/wdata stable while high
//  cpu_we       in   1       1=write, 0=read
//  cpu_addr     in   ADDR_W  CPU word address
//  cpu_wdata    in   DATA_W  CPU write data
//  cpu_gnt      out  1       CPU owns port; transaction accepted at posedge with cpu_req&cpu_gnt
//  cpu_rdata    out  DATA_W  read data of last accepted CPU read
//  cpu_rvalid   out  1       1-cycle pulse: cpu_rdata updated
//  host_req/host_we/host_addr/host_wdata/host_gnt/host_rdata/host_rvalid: same as cpu_* for host
//  mem_addr     out  ADDR_W  to memory address
//  mem_wdata    out  DATA_W  to memory data
//  mem_we       out  1       to memory write enable
//  mem_rdata    in   DATA_W  from memory data_out (combinational)
// BEHAVIOUR
//  Owner register has states ARB_IDLE, ARB_CPU, ARB_HOST.
//  - cpu_gnt = (owner==ARB_CPU); host_gnt = (owner==ARB_HOST).
//  - mem_* is a combinational mux of the owner's command.
//  - mem_we = owner_req & owner_we. In ARB_IDLE: mem_addr=0, mem_wdata=0, mem_we=0.
//  Write: memory commits at the negedge inside the accept cycle. Read: mem_rdata captured at accept
//   posedge into <owner>_rdata; <owner>_rvalid high the following cycle (latency 1 after accept).
//  Next-owner rules (every posedge, in priority order):
//   1. Neither req -> ARB_IDLE.
//   2. Only one req -> that requester.
//   3. Both req, owner X, burst_cnt < MAX_BURST -> stay X.
//   4. Both req, owner X, burst_cnt == MAX_BURST -> other requester.
//   5. Both req from ARB_IDLE -> the one not served last (last_owner); after reset CPU wins.
//  burst_cnt: resets to 1 on owner change; +1 per accepted transaction; saturates at MAX_BURST.
//   MAX_BURST=1 -> strict alternation when both requesters are busy.
//  Grant takes 1 cycle from IDLE: req seen at edge N -> gnt high cycle N+1.
//  Owner dropping req: no transaction that cycle (mem_we=0); ownership re-evaluated next edge.
//  rdata holds its last value until the next accepted read by the same requester.
//  Async reset at any time, including mid-write cycle, takes effect immediately:
//   - owner=ARB_IDLE, last_owner=ARB_HOST, burst_cnt=0.
//   - gnt=0, mem_we=0, so no negedge write is issued.
//   - *_rdata=0, *_rvalid=0.
// CONFIGURATION
//  MEM_ARB_STATS_EN defined: adds stat_clr (in,1), stat_cpu_cnt (out,16), stat_host_cnt (out,16).
//   - Counters count accepted transactions and saturate at 16'hFFFF.
//   - stat_clr zeroes both synchronously; accept and clr in the same cycle -> 0.
//   - Both counters reset to 0.
//  MEM_ARB_STATS_EN undefined: those ports and that logic do not exist; arbitration is identical.
// STRUCTURE
//  mem_arb_pkg holds:
//   - localparams ADDR_W_DEF=5, DATA_W_DEF=32.
//   - typedef enum logic [1:0] arb_owner_t {ARB_IDLE=0, ARB_CPU=1, ARB_HOST=2}.
//  Sub-module mem_arb_stats holds the two saturating counters; instantiated only under MEM_ARB_STATS_EN.
//  Owner FSM, burst counter and rdata capture live in the top level.
// TESTING
//  1. Host writes addr 0..3 = 32'h11,22,33,44 alone -> host_gnt from cycle 2, 4 back-to-back writes.
//     Then CPU reads addr 2 -> cpu_rvalid with cpu_rdata=32'h33.
//  2. Both req continuously, MAX_BURST=4, from reset -> grants CPUx4, HOSTx4, CPUx4, ...
//     No cycle has both gnt high.
//  3. CPU owner drops req mid-burst while host waits -> one cycle with mem_we=0.
//     host_gnt the next cycle; burst_cnt restarts at 1.
//  4. rst_n low during the host write-accept cycle before negedge (addr 7, data 32'hDEAD) -> mem_we=0
//     at once; mem[7] unchanged. After release, IDLE; CPU wins first tie.
//  5. Back-to-back CPU reads addr 5 then addr 6 -> cpu_rvalid 2 consecutive cycles.
//     Data = mem[5], then mem[6].
//  6. With MEM_ARB_STATS_EN: 10 CPU + 3 host transactions -> stat_cpu_cnt=10, stat_host_cnt=3.
//     stat_clr -> both 0 next cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CPU  = 2'd1,
    ARB_HOST = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/mem_arb_stats.sv
// Saturating counters of accepted CPU/host transactions, with synchronous clear.
module mem_arb_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stat_clr,
  input  logic        cpu_acc,
  input  logic        host_acc,
  output logic [15:0] stat_cpu_cnt,
  output logic [15:0] stat_host_cnt
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Clear wins over a same-cycle accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cpu_cnt  <= '0;
      stat_host_cnt <= '0;
    end else if (stat_clr) begin
      stat_cpu_cnt  <= '0;
      stat_host_cnt <= '0;
    end else begin
      if (cpu_acc && (stat_cpu_cnt != CNT_MAX))
        stat_cpu_cnt <= stat_cpu_cnt + CNT_W'(1);
      if (host_acc && (stat_host_cnt != CNT_MAX))
        stat_host_cnt <= stat_host_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter with burst limit sharing one memory port between CPU and host loader.
// Optional transaction statistics when MEM_ARB_STATS_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_cpu_cnt,
  output logic [15:0]       stat_host_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  arb_owner_t       owner;
  arb_owner_t       owner_nxt;
  arb_owner_t       last_owner;
  logic [CNT_W-1:0] burst_cnt;
  logic             cpu_acc;
  logic             host_acc;

  assign cpu_gnt  = (owner == ARB_CPU);
  assign host_gnt = (owner == ARB_HOST);
  assign cpu_acc  = cpu_gnt & cpu_req;
  assign host_acc = host_gnt & host_req;

  // Next owner: idle/single requester first, then burst limit, then round-robin from idle.
  always_comb begin
    owner_nxt = ARB_IDLE;
    if (cpu_req && host_req) begin
      case (owner)
        ARB_CPU:  owner_nxt = (burst_cnt < BURST_MAX) ? ARB_CPU : ARB_HOST;
        ARB_HOST: owner_nxt = (burst_cnt < BURST_MAX) ? ARB_HOST : ARB_CPU;
        default:  owner_nxt = (last_owner == ARB_CPU) ? ARB_HOST : ARB_CPU;
      endcase
    end else if (cpu_req) begin
      owner_nxt = ARB_CPU;
    end else if (host_req) begin
      owner_nxt = ARB_HOST;
    end
  end

  // Memory command mux; idle drives zeros so nothing is written.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    case (owner)
      ARB_CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_req & cpu_we;
      end
      ARB_HOST: begin
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
        mem_we    = host_req & host_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= ARB_IDLE;
      last_owner <= ARB_HOST;
      burst_cnt  <= '0;
    end else begin
      owner <= owner_nxt;
      if (owner != ARB_IDLE)
        last_owner <= owner;
      if (owner_nxt != owner)
        burst_cnt <= CNT_W'(1);
      else if ((cpu_acc || host_acc) && (burst_cnt < BURST_MAX))
        burst_cnt <= burst_cnt + CNT_W'(1);
    end
  end

  // Read data returns to the requester that issued the read, one cycle after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata   <= '0;
      cpu_rvalid  <= 1'b0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      cpu_rvalid  <= cpu_acc & ~cpu_we;
      host_rvalid <= host_acc & ~host_we;
      if (cpu_acc && !cpu_we)
        cpu_rdata <= mem_rdata;
      if (host_acc && !host_we)
        host_rdata <= mem_rdata;
    end
  end

`ifdef MEM_ARB_STATS_EN
  mem_arb_stats u_stats (
    .clk           (clk),
    .rst_n         (rst_n),
    .stat_clr      (stat_clr),
    .cpu_acc       (cpu_acc),
    .host_acc      (host_acc),
    .stat_cpu_cnt  (stat_cpu_cnt),
    .stat_host_cnt (stat_host_cnt)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level reference model.
// Statistics checks are included when MEM_ARB_STATS_EN is defined.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned MB = 4;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req, cpu_we, host_req, host_we;
  logic [AW-1:0] cpu_addr, host_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, host_wdata, mem_wdata, mem_rdata;
  logic          cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, mem_we;
  logic [DW-1:0] cpu_rdata, host_rdata;
  logic [DW-1:0] mem_arr [32];
`ifdef MEM_ARB_STATS_EN
  logic          stat_clr;
  logic [15:0]   stat_cpu_cnt, stat_host_cnt;
  int            m_cpu_stat, m_host_stat;
`endif

  int            n_checks = 0;
  int            n_errors = 0;

  // Reference model state: owner 0=idle 1=cpu 2=host
  cmd_t          cq[$];
  cmd_t          hq[$];
  int            m_owner, m_last, m_served;
  logic [DW-1:0] ref_mem [32];
  logic [DW-1:0] m_cpu_rdata, m_host_rdata;
  logic          m_cpu_rvalid, m_host_rvalid;

  always #5 clk = ~clk;

  assign mem_rdata = mem_arr[mem_addr];
  always @(negedge clk) if (mem_we) mem_arr[mem_addr] <= mem_wdata;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_gnt     (cpu_gnt),
    .cpu_rdata   (cpu_rdata),
    .cpu_rvalid  (cpu_rvalid),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rdata  (host_rdata),
    .host_rvalid (host_rvalid),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_clr      (stat_clr),
    .stat_cpu_cnt  (stat_cpu_cnt),
    .stat_host_cnt (stat_host_cnt)
`endif
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_last = 2; m_served = 0;
    m_cpu_rdata = '0; m_host_rdata = '0;
    m_cpu_rvalid = 1'b0; m_host_rvalid = 1'b0;
`ifdef MEM_ARB_STATS_EN
    m_cpu_stat = 0; m_host_stat = 0;
`endif
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_cpu_gnt"}, DW'(cpu_gnt), DW'(m_owner == 1));
    check({tag, "_host_gnt"}, DW'(host_gnt), DW'(m_owner == 2));
    check({tag, "_excl"}, DW'(cpu_gnt & host_gnt), '0);
    check({tag, "_cpu_rvalid"}, DW'(cpu_rvalid), DW'(m_cpu_rvalid));
    check({tag, "_host_rvalid"}, DW'(host_rvalid), DW'(m_host_rvalid));
    check({tag, "_cpu_rdata"}, cpu_rdata, m_cpu_rdata);
    check({tag, "_host_rdata"}, host_rdata, m_host_rdata);
`ifdef MEM_ARB_STATS_EN
    check({tag, "_stat_cpu"}, DW'(stat_cpu_cnt), DW'(m_cpu_stat));
    check({tag, "_stat_host"}, DW'(stat_host_cnt), DW'(m_host_stat));
`endif
  endtask

  // One clock: drive queue heads (unless held off), check the port mux, step the model.
  task automatic tick(input bit cpu_off, input bit host_off, input bit clr);
    logic          cr, hr, cw, hw, e_we, c_acc, h_acc;
    logic [AW-1:0] ca, ha, e_addr;
    logic [DW-1:0] cd, hd, e_wd;
    int            nxt;
    cr = (cq.size() > 0) && !cpu_off;
    hr = (hq.size() > 0) && !host_off;
    if (cr) begin cw = cq[0].we; ca = cq[0].addr; cd = cq[0].data; end
    else begin cw = 1'($urandom()); ca = AW'($urandom()); cd = $urandom(); end
    if (hr) begin hw = hq[0].we; ha = hq[0].addr; hd = hq[0].data; end
    else begin hw = 1'($urandom()); ha = AW'($urandom()); hd = $urandom(); end
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
`ifdef MEM_ARB_STATS_EN
    stat_clr = clr;
`endif
    #1;
    e_we = 1'b0; e_addr = '0; e_wd = '0;
    if (m_owner == 1) begin e_we = cr & cw; e_addr = ca; e_wd = cd; end
    if (m_owner == 2) begin e_we = hr & hw; e_addr = ha; e_wd = hd; end
    check("mem_we", DW'(mem_we), DW'(e_we));
    check("mem_addr", DW'(mem_addr), DW'(e_addr));
    check("mem_wdata", mem_wdata, e_wd);
    @(posedge clk);
    #1;
    c_acc = (m_owner == 1) && cr;
    h_acc = (m_owner == 2) && hr;
    m_cpu_rvalid  = c_acc && !cw;
    m_host_rvalid = h_acc && !hw;
    if (m_cpu_rvalid) m_cpu_rdata = ref_mem[ca];
    if (m_host_rvalid) m_host_rdata = ref_mem[ha];
    if (c_acc && cw) ref_mem[ca] = cd;
    if (h_acc && hw) ref_mem[ha] = hd;
    if (c_acc) void'(cq.pop_front());
    if (h_acc) void'(hq.pop_front());
`ifdef MEM_ARB_STATS_EN
    if (clr) begin m_cpu_stat = 0; m_host_stat = 0; end
    else begin
      if (c_acc && m_cpu_stat < 65535) m_cpu_stat++;
      if (h_acc && m_host_stat < 65535) m_host_stat++;
    end
`else
    if (clr) nxt = 0;
`endif
    if (c_acc || h_acc) m_served++;
    if (cr && hr) begin
      if (m_owner == 0) nxt = (m_last == 1) ? 2 : 1;
      else nxt = (m_served < int'(MB)) ? m_owner : 3 - m_owner;
    end else if (cr) nxt = 1;
    else if (hr) nxt = 2;
    else nxt = 0;
    if (m_owner != 0) m_last = m_owner;
    if (nxt != m_owner) m_served = 0;
    m_owner = nxt;
    check_regs("cyc");
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((cq.size() > 0 || hq.size() > 0) && n < max_cycles) begin
      tick(1'b0, 1'b0, 1'b0);
      n++;
    end
    check("drain_timeout", DW'(cq.size() + hq.size()), '0);
  endtask

  task automatic reset_dut();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
`ifdef MEM_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    rst_n = 1'b0;
    model_reset();
    cq.delete(); hq.delete();
    @(posedge clk); #1;
    check_regs("rst");
    check("rst_mem_we", DW'(mem_we), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  function automatic cmd_t mk(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    cmd_t c;
    c.we = we; c.addr = addr; c.data = data;
    return c;
  endfunction

  initial begin
    logic [DW-1:0] pre7;
    int            n;
    for (int i = 0; i < 32; i++) begin
      mem_arr[i] = $urandom();
      ref_mem[i] = mem_arr[i];
    end
    reset_dut();

    // Host loads four words alone, then CPU reads one back
    for (int i = 0; i < 4; i++) hq.push_back(mk(1'b1, AW'(i), DW'((i + 1) * 'h11)));
    drain(20);
    cq.push_back(mk(1'b0, AW'(2), '0));
    n = 0;
    do begin tick(1'b0, 1'b0, 1'b0); n++; end while (!cpu_rvalid && n < 10);
    check("t1_rvalid", DW'(cpu_rvalid), 1);
    check("t1_rdata", cpu_rdata, 32'h33);
    tick(1'b0, 1'b0, 1'b0);

    // Both requesting from reset: idle, then CPUx4, HOSTx4, CPUx4, HOSTx4
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      cq.push_back(mk(1'($urandom()), AW'($urandom()), $urandom()));
      hq.push_back(mk(1'($urandom()), AW'($urandom()), $urandom()));
    end
    tick(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      tick(1'b0, 1'b0, 1'b0);
      check("t2_cpu_pattern", DW'(cpu_gnt), DW'(((k + 1) / 4) % 2 == 0 && k != 15));
    end
    drain(20);

    // CPU drops request mid-burst while host waits
    tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cq.push_back(mk(1'b1, AW'(20 + i), $urandom()));
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) hq.push_back(mk(1'b0, AW'(20 + i), '0));
    tick(1'b1, 1'b0, 1'b0);
    check("t3_host_gnt", DW'(host_gnt), 1);
    drain(30);

    // Back-to-back CPU reads
    cq.push_back(mk(1'b0, AW'(5), '0));
    cq.push_back(mk(1'b0, AW'(6), '0));
    drain(10);
    tick(1'b0, 1'b0, 1'b0);

    // Asynchronous reset inside a host write-accept cycle
    hq.push_back(mk(1'b1, AW'(7), 32'hDEAD));
    tick(1'b0, 1'b0, 1'b0);
    check("t4_host_owns", DW'(host_gnt), 1);
    pre7 = ref_mem[7];
    host_req = 1'b1; host_we = 1'b1; host_addr = AW'(7); host_wdata = 32'hDEAD;
    #1;
    check("t4_we_before", DW'(mem_we), 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    hq.delete();
    check("t4_we_reset", DW'(mem_we), '0);
    check_regs("t4");
    @(negedge clk); #1;
    check("t4_mem7", mem_arr[7], pre7);
    host_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cq.push_back(mk(1'b0, AW'(7), '0));
    hq.push_back(mk(1'b0, AW'(7), '0));
    tick(1'b0, 1'b0, 1'b0);
    check("t4_tie_cpu", DW'(cpu_gnt), 1);
    drain(20);

`ifdef MEM_ARB_STATS_EN
    // Statistics: 10 CPU + 3 host transactions, then clear
    reset_dut();
    for (int i = 0; i < 10; i++) cq.push_back(mk(1'($urandom()), AW'($urandom()), $urandom()));
    for (int i = 0; i < 3; i++) hq.push_back(mk(1'($urandom()), AW'($urandom()), $urandom()));
    drain(40);
    tick(1'b0, 1'b0, 1'b0);
    check("t6_cpu_cnt", DW'(stat_cpu_cnt), 10);
    check("t6_host_cnt", DW'(stat_host_cnt), 3);
    tick(1'b0, 1'b0, 1'b1);
    check("t6_clr_cpu", DW'(stat_cpu_cnt), '0);
    check("t6_clr_host", DW'(stat_host_cnt), '0);
`endif

    // Random traffic with request drops and occasional stat clears
    for (int c = 0; c < 800; c++) begin
      if (cq.size() < 3 && $urandom_range(2) == 0)
        cq.push_back(mk(1'($urandom()), AW'($urandom()), $urandom()));
      if (hq.size() < 3 && $urandom_range(2) == 0)
        hq.push_back(mk(1'($urandom()), AW'($urandom()), $urandom()));
      tick($urandom_range(9) == 0, $urandom_range(9) == 0, $urandom_range(39) == 0);
    end
    drain(40);

    // Final readback of the whole memory through the CPU port
    for (int i = 0; i < 32; i++) cq.push_back(mk(1'b0, AW'(i), '0));
    drain(60);
    tick(1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
